// File: rtl/cpu_execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, multi-cycle shift-add multiplier,
// and the execute-to-commit pipeline register with a busy stall back to decode.
module cpu_execute_stage #(
    parameter int REG_WIDTH          = 32,
    parameter int VIRTUAL_ADDR_WIDTH = 32,
    parameter int NUM_REGS           = 32,
    parameter int NUM_ALU_OPS        = 8,
    localparam int ID_W              = $clog2(NUM_REGS),
    localparam int OP_W              = $clog2(NUM_ALU_OPS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [OP_W-1:0]               in_alu_op,
    input  logic                          in_use_reg_b,
    input  logic                          in_mem_write,
    input  logic                          in_mem_read,
    input  logic                          in_mem_to_reg,
    input  logic                          in_reg_write,
    input  logic [VIRTUAL_ADDR_WIDTH-1:0] in_next_PC,
    input  logic [REG_WIDTH-1:0]          in_ra_data,
    input  logic [REG_WIDTH-1:0]          in_rb_data,
    input  logic [REG_WIDTH-1:0]          in_offset_data,
    input  logic [ID_W-1:0]               in_ra_id,
    input  logic [ID_W-1:0]               in_rb_id,
    input  logic [ID_W-1:0]               in_reg_dest,
    input  logic                          wb_valid,
    input  logic                          wb_reg_write,
    input  logic [ID_W-1:0]               wb_reg_dest,
    input  logic [REG_WIDTH-1:0]          wb_data,
    input  logic                          commit_stall,
    input  logic                          flush,
    output logic                          ex_busy,
    output logic                          out_valid,
    output logic                          out_mem_write,
    output logic                          out_mem_read,
    output logic                          out_mem_to_reg,
    output logic                          out_reg_write,
    output logic [ID_W-1:0]               out_reg_dest,
    output logic [REG_WIDTH-1:0]          out_alu_result,
    output logic [REG_WIDTH-1:0]          out_store_data,
    output logic [VIRTUAL_ADDR_WIDTH-1:0] out_next_PC
);

    localparam int CNT_W = $clog2(REG_WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(REG_WIDTH - 1);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_PASSB = OP_W'(6);
    localparam logic [OP_W-1:0] OP_MUL   = OP_W'(7);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]                    state;
    logic [CNT_W-1:0]              count;
    logic [REG_WIDTH-1:0]          mul_a, mul_b, mul_acc, mul_partial;
    logic                          p_mem_write, p_mem_read, p_mem_to_reg, p_reg_write;
    logic [ID_W-1:0]               p_reg_dest;
    logic [VIRTUAL_ADDR_WIDTH-1:0] p_next_pc;
    logic [REG_WIDTH-1:0]          p_store_data;

    logic                 ra_from_out, ra_from_wb, rb_from_out, rb_from_wb;
    logic [REG_WIDTH-1:0] ra_fwd, rb_fwd, op_b, alu_result;

    // The output register outranks writeback because it holds the younger value;
    // loads are excluded since their data is not known until the memory stage.
    assign ra_from_out = (in_ra_id != '0) & out_valid & out_reg_write & ~out_mem_read
                         & (out_reg_dest == in_ra_id);
    assign rb_from_out = (in_rb_id != '0) & out_valid & out_reg_write & ~out_mem_read
                         & (out_reg_dest == in_rb_id);
    assign ra_from_wb  = (in_ra_id != '0) & wb_valid & wb_reg_write & (wb_reg_dest == in_ra_id);
    assign rb_from_wb  = (in_rb_id != '0) & wb_valid & wb_reg_write & (wb_reg_dest == in_rb_id);

    assign ra_fwd = ra_from_out ? out_alu_result : (ra_from_wb ? wb_data : in_ra_data);
    assign rb_fwd = rb_from_out ? out_alu_result : (rb_from_wb ? wb_data : in_rb_data);
    assign op_b   = in_use_reg_b ? rb_fwd : in_offset_data;

    always_comb begin
        alu_result = '0;
        case (in_alu_op)
            OP_ADD:   alu_result = ra_fwd + op_b;
            OP_SUB:   alu_result = ra_fwd - op_b;
            OP_AND:   alu_result = ra_fwd & op_b;
            OP_OR:    alu_result = ra_fwd | op_b;
            OP_XOR:   alu_result = ra_fwd ^ op_b;
            OP_SLT:   alu_result = {{(REG_WIDTH-1){1'b0}}, ($signed(ra_fwd) < $signed(op_b))};
            OP_PASSB: alu_result = op_b;
            default:  alu_result = '0;
        endcase
    end

    assign mul_partial = mul_b[0] ? mul_a : '0;
    assign ex_busy     = (state == ST_MUL) | commit_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            count          <= '0;
            mul_a          <= '0;
            mul_b          <= '0;
            mul_acc        <= '0;
            p_mem_write    <= 1'b0;
            p_mem_read     <= 1'b0;
            p_mem_to_reg   <= 1'b0;
            p_reg_write    <= 1'b0;
            p_reg_dest     <= '0;
            p_next_pc      <= '0;
            p_store_data   <= '0;
            out_valid      <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_reg_write  <= 1'b0;
            out_reg_dest   <= '0;
            out_alu_result <= '0;
            out_store_data <= '0;
            out_next_PC    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
            count     <= '0;
        end else if (state == ST_IDLE) begin
            if (!commit_stall) begin
                if (in_valid && in_alu_op == OP_MUL) begin
                    mul_a        <= ra_fwd;
                    mul_b        <= op_b;
                    mul_acc      <= '0;
                    count        <= '0;
                    p_mem_write  <= in_mem_write;
                    p_mem_read   <= in_mem_read;
                    p_mem_to_reg <= in_mem_to_reg;
                    p_reg_write  <= in_reg_write;
                    p_reg_dest   <= in_reg_dest;
                    p_next_pc    <= in_next_PC;
                    p_store_data <= rb_fwd;
                    out_valid    <= 1'b0;
                    state        <= ST_MUL;
                end else if (in_valid) begin
                    out_valid      <= 1'b1;
                    out_mem_write  <= in_mem_write;
                    out_mem_read   <= in_mem_read;
                    out_mem_to_reg <= in_mem_to_reg;
                    out_reg_write  <= in_reg_write;
                    out_reg_dest   <= in_reg_dest;
                    out_alu_result <= alu_result;
                    out_store_data <= rb_fwd;
                    out_next_PC    <= in_next_PC;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end else if (count == LAST_COUNT) begin
            // Final iteration folds straight into the output register; it waits out commit_stall.
            if (!commit_stall) begin
                out_valid      <= 1'b1;
                out_mem_write  <= p_mem_write;
                out_mem_read   <= p_mem_read;
                out_mem_to_reg <= p_mem_to_reg;
                out_reg_write  <= p_reg_write;
                out_reg_dest   <= p_reg_dest;
                out_alu_result <= mul_acc + mul_partial;
                out_store_data <= p_store_data;
                out_next_PC    <= p_next_pc;
                state          <= ST_IDLE;
            end
        end else begin
            mul_acc <= mul_acc + mul_partial;
            mul_a   <= mul_a << 1;
            mul_b   <= mul_b >> 1;
            count   <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_execute_stage.sv
// Self-checking bench for cpu_execute_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_cpu_execute_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_use_reg_b, in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write;
    logic [2:0]  in_alu_op;
    logic [31:0] in_next_PC, in_ra_data, in_rb_data, in_offset_data, wb_data;
    logic [4:0]  in_ra_id, in_rb_id, in_reg_dest, wb_reg_dest;
    logic        wb_valid, wb_reg_write, commit_stall, flush;
    logic        ex_busy, out_valid, out_mem_write, out_mem_read, out_mem_to_reg, out_reg_write;
    logic [4:0]  out_reg_dest;
    logic [31:0] out_alu_result, out_store_data, out_next_PC;

    cpu_execute_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_alu_op(in_alu_op),
        .in_use_reg_b(in_use_reg_b), .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write), .in_next_PC(in_next_PC),
        .in_ra_data(in_ra_data), .in_rb_data(in_rb_data), .in_offset_data(in_offset_data),
        .in_ra_id(in_ra_id), .in_rb_id(in_rb_id), .in_reg_dest(in_reg_dest),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg_dest(wb_reg_dest),
        .wb_data(wb_data), .commit_stall(commit_stall), .flush(flush), .ex_busy(ex_busy),
        .out_valid(out_valid), .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
        .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
        .out_reg_dest(out_reg_dest), .out_alu_result(out_alu_result),
        .out_store_data(out_store_data), .out_next_PC(out_next_PC)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int last_busy;

    // Reference model: committed output register plus a pending multiply with a cycle countdown.
    logic        m_valid, m_mw, m_mr, m_m2r, m_rw;
    logic [4:0]  m_dest;
    logic [31:0] m_res, m_sd, m_pc;
    int          m_cnt;
    logic        p_mw, p_mr, p_m2r, p_rw;
    logic [4:0]  p_dest;
    logic [31:0] p_res, p_sd, p_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return b;
            default: return a * b;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] id, input logic [31:0] raw);
        if (id != 5'd0 && m_valid && m_rw && !m_mr && m_dest == id) return m_res;
        if (id != 5'd0 && wb_valid && wb_reg_write && wb_reg_dest == id) return wb_data;
        return raw;
    endfunction

    task automatic model_edge();
        logic [31:0] a, rb, b, r;
        a  = ref_fwd(in_ra_id, in_ra_data);
        rb = ref_fwd(in_rb_id, in_rb_data);
        b  = in_use_reg_b ? rb : in_offset_data;
        r  = ref_alu(in_alu_op, a, b);
        if (reset) begin
            {m_valid, m_mw, m_mr, m_m2r, m_rw} = '0;
            m_dest = '0; m_res = '0; m_sd = '0; m_pc = '0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 1'b0;
            m_cnt   = 0;
        end else if (m_cnt > 0) begin
            if (m_cnt == 1) begin
                if (!commit_stall) begin
                    m_valid = 1'b1; m_mw = p_mw; m_mr = p_mr; m_m2r = p_m2r; m_rw = p_rw;
                    m_dest = p_dest; m_res = p_res; m_sd = p_sd; m_pc = p_pc; m_cnt = 0;
                end
            end else begin
                m_cnt--;
            end
        end else if (!commit_stall) begin
            if (in_valid && in_alu_op == 3'd7) begin
                p_mw = in_mem_write; p_mr = in_mem_read; p_m2r = in_mem_to_reg; p_rw = in_reg_write;
                p_dest = in_reg_dest; p_res = r; p_sd = rb; p_pc = in_next_PC;
                m_cnt = 32; m_valid = 1'b0;
            end else if (in_valid) begin
                m_valid = 1'b1; m_mw = in_mem_write; m_mr = in_mem_read; m_m2r = in_mem_to_reg;
                m_rw = in_reg_write; m_dest = in_reg_dest; m_res = r; m_sd = rb; m_pc = in_next_PC;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: check ex_busy before the edge, advance model and DUT, check outputs after.
    task automatic cycle();
        #2;
        chk("ex_busy", 32'(ex_busy), 32'((m_cnt > 0) || commit_stall));
        last_busy = int'(ex_busy);
        model_edge();
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("out_reg_dest", 32'(out_reg_dest), 32'(m_dest));
            chk("out_alu_result", out_alu_result, m_res);
            chk("out_store_data", out_store_data, m_sd);
            chk("out_next_PC", out_next_PC, m_pc);
            chk("out_mem_write", 32'(out_mem_write), 32'(m_mw));
            chk("out_mem_read", 32'(out_mem_read), 32'(m_mr));
            chk("out_mem_to_reg", 32'(out_mem_to_reg), 32'(m_m2r));
            chk("out_reg_write", 32'(out_reg_write), 32'(m_rw));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ctl"}, 32'({out_mem_write, out_mem_read, out_mem_to_reg, out_reg_write}), 32'd0);
        chk({tag, "_dest"}, 32'(out_reg_dest), 32'd0);
        chk({tag, "_res"}, out_alu_result, 32'd0);
        chk({tag, "_sd"}, out_store_data, 32'd0);
        chk({tag, "_pc"}, out_next_PC, 32'd0);
        chk({tag, "_busy"}, 32'(ex_busy), 32'd0);
    endtask

    task automatic instr(input logic [2:0] op, input logic ub, input logic [4:0] ra_id,
                         input logic [31:0] ra, input logic [4:0] rb_id, input logic [31:0] rb,
                         input logic [31:0] off, input logic [4:0] dest, input logic rw,
                         input logic mw);
        in_valid = 1'b1; in_alu_op = op; in_use_reg_b = ub;
        in_ra_id = ra_id; in_ra_data = ra; in_rb_id = rb_id; in_rb_data = rb;
        in_offset_data = off; in_reg_dest = dest; in_reg_write = rw; in_mem_write = mw;
        in_mem_read = 1'b0; in_mem_to_reg = 1'b0; in_next_PC = $urandom();
    endtask

    initial begin
        int edges, busy;
        logic done;
        m_cnt = 0; m_valid = 1'b0;
        reset = 1'b1; flush = 1'b0; commit_stall = 1'b0;
        wb_valid = 1'b0; wb_reg_write = 1'b0; wb_reg_dest = '0; wb_data = '0;
        instr(3'd0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
        check_zero("reset");

        instr(3'd0, 1'b1, 5'd2, 32'd5, 5'd3, 32'd7, 32'd0, 5'd1, 1'b1, 1'b0);
        cycle(); chk("add_first", out_alu_result, 32'd12);
        instr(3'd0, 1'b0, 5'd1, 32'd0, 5'd0, 32'd0, 32'd3, 5'd4, 1'b1, 1'b0);
        cycle(); chk("add_out_fwd", out_alu_result, 32'd15);

        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_reg_dest = 5'd6; wb_data = 32'hAA;
        instr(3'd0, 1'b1, 5'd0, 32'd0, 5'd6, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        cycle(); chk("wb_fwd_store", out_store_data, 32'hAA);
        instr(3'd0, 1'b0, 5'd0, 32'h55, 5'd0, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0);
        cycle();
        instr(3'd0, 1'b1, 5'd0, 32'd0, 5'd6, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        cycle(); chk("out_beats_wb", out_store_data, 32'h55);
        wb_reg_dest = 5'd0;
        instr(3'd0, 1'b1, 5'd0, 32'd0, 5'd0, 32'h11, 32'd0, 5'd0, 1'b0, 1'b1);
        cycle(); chk("r0_no_fwd", out_store_data, 32'h11);
        wb_valid = 1'b0;

        instr(3'd7, 1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd3, 5'd7, 1'b1, 1'b0);
        cycle(); chk("mul_bubble", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        edges = 0; busy = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            cycle(); edges++; busy += last_busy;
            if (out_valid) done = 1'b1;
        end
        chk("mul_latency", 32'(edges), 32'd32);
        chk("mul_busy_cycles", 32'(busy), 32'd32);
        chk("mul_result", out_alu_result, 32'hFFFF_FFFD);
        instr(3'd0, 1'b0, 5'd7, 32'd0, 5'd0, 32'd0, 32'd4, 5'd8, 1'b1, 1'b0);
        cycle(); chk("add_after_mul", out_alu_result, 32'd1);

        instr(3'd5, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd1, 32'd0, 5'd9, 1'b1, 1'b0);
        cycle(); chk("slt_signed", out_alu_result, 32'd1);
        instr(3'd1, 1'b1, 5'd0, 32'd0, 5'd0, 32'd1, 32'd0, 5'd9, 1'b1, 1'b0);
        cycle(); chk("sub_wrap", out_alu_result, 32'hFFFF_FFFF);

        instr(3'd0, 1'b0, 5'd0, 32'h100, 5'd0, 32'd0, 32'h23, 5'd9, 1'b1, 1'b0);
        cycle();
        commit_stall = 1'b1;
        instr(3'd0, 1'b0, 5'd0, 32'd1, 5'd0, 32'd0, 32'd1, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_hold", out_alu_result, 32'h123);
            chk("stall_busy", 32'(last_busy), 32'd1);
        end
        commit_stall = 1'b0;
        cycle(); chk("stall_release", out_alu_result, 32'd2);

        instr(3'd7, 1'b1, 5'd0, 32'd1000, 5'd0, 32'd77, 32'd0, 5'd11, 1'b1, 1'b0);
        cycle(); in_valid = 1'b0;
        for (int i = 0; i < 31; i++) cycle();
        commit_stall = 1'b1;
        cycle(); cycle();
        chk("mul_final_stalled", 32'(out_valid), 32'd0);
        commit_stall = 1'b0;
        cycle();
        chk("mul_after_stall_valid", 32'(out_valid), 32'd1);
        chk("mul_after_stall_res", out_alu_result, 32'd77000);

        instr(3'd7, 1'b1, 5'd0, 32'd5, 5'd0, 32'd6, 32'd0, 5'd12, 1'b1, 1'b0);
        cycle(); in_valid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        flush = 1'b1; cycle(); flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(ex_busy), 32'd0);
        cycle();

        instr(3'd7, 1'b1, 5'd0, 32'd9, 5'd0, 32'd9, 32'd0, 5'd13, 1'b1, 1'b0);
        cycle(); in_valid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        reset = 1'b1; cycle(); reset = 1'b0;
        check_zero("reset_mid_mul");

        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 499) == 0);
            flush        = ($urandom_range(0, 59) == 0);
            commit_stall = ($urandom_range(0, 5) == 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            in_alu_op    = ($urandom_range(0, 11) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            in_use_reg_b = 1'($urandom_range(0, 1));
            in_mem_write = 1'($urandom_range(0, 1));
            in_mem_read  = ($urandom_range(0, 3) == 0);
            in_mem_to_reg = 1'($urandom_range(0, 1));
            in_reg_write = ($urandom_range(0, 3) != 0);
            in_next_PC   = $urandom();
            in_ra_data   = $urandom();
            in_rb_data   = $urandom();
            in_offset_data = $urandom();
            in_ra_id     = 5'($urandom_range(0, 3));
            in_rb_id     = 5'($urandom_range(0, 3));
            in_reg_dest  = 5'($urandom_range(0, 3));
            wb_valid     = 1'($urandom_range(0, 1));
            wb_reg_write = 1'($urandom_range(0, 1));
            wb_reg_dest  = 5'($urandom_range(0, 3));
            wb_data      = $urandom();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_execute_stage.md
Name: cpu_execute_stage

Overview:
- Consumer (slave end) of the decode-to-execute bundle: writeback, commit and execute control, next_PC, ra/rb/offset data, ra_id/rb_id/reg_dest.
- Forwards operands, runs the ALU, and runs a multi-cycle shift-add multiplier.
- Registers results into the execute-to-commit pipeline register that feeds the memory/commit stage.
- Drives a busy stall back to the decode-to-execute register.

Parameters:
- REG_WIDTH, 32, datapath width.
- VIRTUAL_ADDR_WIDTH, 32, PC width.
- NUM_REGS, 32, register count; register ids are $clog2(NUM_REGS) bits wide.
- NUM_ALU_OPS, 8, ALU op count; alu_op is $clog2(NUM_ALU_OPS) bits wide.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode-to-execute bundle holds a real instruction
- in_alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 PASSB, 7 MUL
- in_use_reg_b  in  1  1: operand B = rb; 0: operand B = offset_data
- in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write  in  1 each  control passed through
- in_next_PC  in  VIRTUAL_ADDR_WIDTH  passed through
- in_ra_data, in_rb_data, in_offset_data  in  REG_WIDTH  operands
- in_ra_id, in_rb_id, in_reg_dest  in  5  register ids
- wb_valid, wb_reg_write  in  1  writeback stage holds a valid register write
- wb_reg_dest  in  5  writeback destination
- wb_data  in  REG_WIDTH  writeback data
- commit_stall  in  1  commit stage cannot accept
- flush  in  1  kill the in-flight execute work
- ex_busy  out  1  hold the decode-to-execute register
- out_valid, out_mem_write, out_mem_read, out_mem_to_reg, out_reg_write  out  1 each  execute-to-commit register
- out_reg_dest  out  5  destination id
- out_alu_result, out_store_data  out  REG_WIDTH  ALU result; forwarded rb value
- out_next_PC  out  VIRTUAL_ADDR_WIDTH  passed through

Behaviour:
- Reset (sync, high): all out_* = 0, FSM = IDLE, count = 0, multiplier registers = 0. ex_busy = 0 follows.
- Forwarding for ra and rb (independently). Register 0 never forwards. Priority:
  - First: own output register, when out_valid & out_reg_write & !out_mem_read & out_reg_dest == id.
  - Second: writeback port, when wb_valid & wb_reg_write & wb_reg_dest == id.
  - Otherwise: in_ra_data / in_rb_data.
  - Load-use hazards are detected in decode, not here.
- Operand B = in_use_reg_b ? forwarded rb : in_offset_data.
- out_store_data = forwarded rb, always.
- ALU results are REG_WIDTH bits, wrap mod 2^REG_WIDTH. SLT gives 1 or 0, zero-extended.
- ex_busy = (state == MUL) | commit_stall. It is combinational.
- FSM IDLE:
  - If in_valid & op != MUL & !commit_stall: out_* load the result at the edge, with out_valid = 1. Latency is 1 cycle.
  - If in_valid & op == MUL & !commit_stall: latch A, B, the controls and dest; set count = 0; state goes to MUL; out_valid <= 0 (bubble). ex_busy is 0 in this acceptance cycle, so decode advances.
  - If !in_valid: out_valid <= 0 unless commit_stall.
- FSM MUL:
  - One shift-add iteration per cycle: if B[0], add A to the accumulator; A <<= 1; B >>= 1; count++.
  - When count == REG_WIDTH-1 and !commit_stall: load out_* with the product low REG_WIDTH bits, set out_valid = 1, return to IDLE.
  - This gives out_valid exactly REG_WIDTH cycles after the acceptance edge.
  - If commit_stall is high at the final count: count and accumulator hold until commit_stall drops.
- commit_stall: out_* hold their values; no new IDLE acceptance.
- flush: at the next edge out_valid = 0 (other out_* don't care) and FSM goes to IDLE, aborting a MUL.
  - flush beats commit_stall and acceptance.
  - reset beats flush.
- Signed/unsigned MUL give identical low bits; no high half is produced.

Test Plan:
- ADD back-to-back: I1 ADD r1 = r2(5) + r3(7), then I2 ADD r4 = r1 + offset 3 (use_reg_b = 0) -> out_alu_result 12, then 15 via own-register forwarding.
- WB forward: wb_valid, wb_reg_write, dest r6, wb_data 0xAA, with in_rb_id = 6 and stale rb 0 on a store -> out_store_data 0xAA. If r6 also sits in the output register, the output register value wins. Dest r0 -> no forward.
- MUL: 0xFFFF_FFFF * 3 -> ex_busy high for 32 cycles, then out_valid with result 0xFFFF_FFFD at the 32nd edge after acceptance. The following ADD completes on the next cycle.
- SLT signed: -1 vs 1 -> 1. SUB: 0 - 1 -> 0xFFFF_FFFF.
- commit_stall for 3 cycles during an ADD result -> out_* stable, ex_busy high. A final MUL iteration stalled 2 cycles -> result appears after stall release.
- flush at MUL cycle 10 -> out_valid 0, state IDLE, ex_busy 0 the next cycle. Reset mid-MUL -> all outputs 0 the next cycle.
